// File: rtl/alu_operand_sequencer_pkg.sv
// Shared types for the 6502-style ALU operand sequencer: operation codes,
// sequencer states and the page-cross fix-up rule.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_CMP   = 3'd2,
    OP_INDEX = 3'd3,
    OP_REL   = 3'd4,
    OP_INC   = 3'd5
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_FIXUP,
    ST_DONE
  } alu_seq_state_t;

  // Reserved codes 6 and 7 behave as ADD.
  function automatic alu_op_t normalize_op(input alu_op_t raw);
    case (raw)
      OP_SUB, OP_CMP, OP_INDEX, OP_REL, OP_INC: return raw;
      default:                                  return OP_ADD;
    endcase
  endfunction

  // INDEX and forward REL fix up on a carry out of the low byte; a backward
  // REL (negative offset) fixes up when there is no carry.
  function automatic logic needs_fixup(input alu_op_t op, input logic cout,
                                       input logic sign);
    case (op)
      OP_INDEX: return cout;
      OP_REL:   return sign ? !cout : cout;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Request/stall/feedback inputs and ALU control outputs of the sequencer.
interface alu_operand_sequencer_if;
  import alu_seq_pkg::*;

  logic    rdy;
  logic    start;
  alu_op_t op;
  logic    carry_flag;
  logic    alu_cout;
  logic    b_sign;

  logic    db_add;
  logic    not_db_add;
  logic    adl_add;
  logic    sb_add;
  logic    zero_add;
  logic    alu_cin;
  logic    add_sb;
  logic    add_adl;
  logic    flags_we;
  logic    adh_inc;
  logic    adh_dec;
  logic    busy;
  logic    done;

  modport slave (
    input  rdy, start, op, carry_flag, alu_cout, b_sign,
    output db_add, not_db_add, adl_add, sb_add, zero_add, alu_cin,
           add_sb, add_adl, flags_we, adh_inc, adh_dec, busy, done
  );

  modport master (
    output rdy, start, op, carry_flag, alu_cout, b_sign,
    input  db_add, not_db_add, adl_add, sb_add, zero_add, alu_cin,
           add_sb, add_adl, flags_we, adh_inc, adh_dec, busy, done
  );

endinterface

// File: rtl/alu_operand_sequencer.sv
// Drives ALU input selects, carry-in, result routing and ADH fix-up strobes
// for one operation over the IDLE/LOAD/EXEC/FIXUP/DONE schedule.
module alu_operand_sequencer
  import alu_seq_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  alu_operand_sequencer_if.slave  bus
);

  alu_seq_state_t state_q, state_d;
  alu_op_t        op_q, op_d;
  logic           carry_q, carry_d;
  logic           fix_dec_q, fix_dec_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ADD;
      carry_q   <= 1'b0;
      fix_dec_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      carry_q   <= carry_d;
      fix_dec_q <= fix_dec_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    carry_d   = carry_q;
    fix_dec_d = fix_dec_q;
    if (bus.rdy) begin
      case (state_q)
        ST_IDLE: if (bus.start) begin
          state_d = ST_LOAD;
          op_d    = normalize_op(bus.op);
          carry_d = bus.carry_flag;
        end
        ST_LOAD: state_d = ST_EXEC;
        ST_EXEC: begin
          if (needs_fixup(op_q, bus.alu_cout, bus.b_sign)) begin
            state_d   = ST_FIXUP;
            fix_dec_d = (op_q == OP_REL) && bus.b_sign;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_FIXUP: state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  logic db_add, not_db_add, adl_add, sb_add, zero_add, alu_cin;
  logic add_sb, add_adl, flags_we, adh_inc, adh_dec, busy, done;

  // Strobes that change architectural state are qualified by rdy; steering
  // signals (carry-in, routing, busy) follow the state alone.
  always_comb begin
    db_add     = 1'b0;
    not_db_add = 1'b0;
    adl_add    = 1'b0;
    sb_add     = 1'b0;
    zero_add   = 1'b0;
    alu_cin    = 1'b0;
    add_sb     = 1'b0;
    add_adl    = 1'b0;
    flags_we   = 1'b0;
    adh_inc    = 1'b0;
    adh_dec    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    if (reset) begin
      busy = (state_q != ST_IDLE);
      case (state_q)
        ST_LOAD: if (bus.rdy) begin
          zero_add   = (op_q == OP_INC);
          sb_add     = (op_q != OP_INC);
          not_db_add = (op_q == OP_SUB) || (op_q == OP_CMP);
          adl_add    = (op_q == OP_INDEX);
          db_add     = !not_db_add && !adl_add;
        end
        ST_EXEC: begin
          case (op_q)
            OP_ADD, OP_SUB:  alu_cin = carry_q;
            OP_CMP, OP_INC:  alu_cin = 1'b1;
            default:         alu_cin = 1'b0;
          endcase
          add_sb   = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_INC);
          add_adl  = (op_q == OP_INDEX) || (op_q == OP_REL);
          flags_we = bus.rdy && !add_adl;
        end
        ST_FIXUP: begin
          adh_inc = bus.rdy && !fix_dec_q;
          adh_dec = bus.rdy && fix_dec_q;
        end
        ST_DONE: done = bus.rdy;
        default: ;
      endcase
    end
  end

  assign bus.db_add     = db_add;
  assign bus.not_db_add = not_db_add;
  assign bus.adl_add    = adl_add;
  assign bus.sb_add     = sb_add;
  assign bus.zero_add   = zero_add;
  assign bus.alu_cin    = alu_cin;
  assign bus.add_sb     = add_sb;
  assign bus.add_adl    = add_adl;
  assign bus.flags_we   = flags_we;
  assign bus.adh_inc    = adh_inc;
  assign bus.adh_dec    = adh_dec;
  assign bus.busy       = busy;
  assign bus.done       = done;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized bench: a queue-of-steps schedule model predicts every output of
// the sequencer each cycle under random requests, stalls and resets.
module tb_alu_operand_sequencer;
  import alu_seq_pkg::*;

  typedef enum int {S_LOAD, S_EXEC, S_FIXUP, S_DONE} step_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_operand_sequencer_if bus ();

  alu_operand_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // Output bundle: {db,ndb,adl,sb,zero,cin,add_sb,add_adl,flags,inc,dec,busy,done}
  logic [12:0] observed;
  assign observed = {bus.db_add, bus.not_db_add, bus.adl_add, bus.sb_add,
                     bus.zero_add, bus.alu_cin, bus.add_sb, bus.add_adl,
                     bus.flags_we, bus.adh_inc, bus.adh_dec, bus.busy, bus.done};

  task automatic check(input string tag, input logic [12:0] got,
                       input logic [12:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  // Reference model state
  step_t   sched[$];
  int      m_op;       // 0..5 after folding reserved codes to ADD
  logic    m_carry;
  logic    m_backward;

  function automatic logic [12:0] predict(input logic rst_n, input logic rdy);
    logic db, ndb, adl, sb, zr, cin, asb, aadl, fw, inc, dec, bsy, dn;
    {db, ndb, adl, sb, zr, cin, asb, aadl, fw, inc, dec, bsy, dn} = '0;
    if (rst_n && sched.size() != 0) begin
      bsy = 1'b1;
      case (sched[0])
        S_LOAD: if (rdy) begin
          // A side: INC adds to zero, everything else to SB.
          if (m_op == 5) zr = 1'b1; else sb = 1'b1;
          // B side: subtract/compare invert DB; INDEX uses ADL; rest DB.
          if (m_op == 1 || m_op == 2) ndb = 1'b1;
          else if (m_op == 3)         adl = 1'b1;
          else                        db  = 1'b1;
        end
        S_EXEC: begin
          if (m_op <= 1)                 cin = m_carry;
          else if (m_op == 2 || m_op == 5) cin = 1'b1;
          asb  = (m_op == 0 || m_op == 1 || m_op == 5);
          aadl = (m_op == 3 || m_op == 4);
          fw   = rdy && (m_op inside {0, 1, 2, 5});
        end
        S_FIXUP: if (rdy) begin
          if (m_backward) dec = 1'b1; else inc = 1'b1;
        end
        S_DONE: dn = rdy;
        default: ;
      endcase
    end
    return {db, ndb, adl, sb, zr, cin, asb, aadl, fw, inc, dec, bsy, dn};
  endfunction

  task automatic advance_model(input logic rst_n, input logic rdy,
                               input logic start, input int op_raw,
                               input logic carry, input logic cout,
                               input logic sign);
    step_t s;
    logic  page_cross;
    if (!rst_n) begin
      sched.delete();
      return;
    end
    if (!rdy) return;
    if (sched.size() == 0) begin
      if (start) begin
        m_op    = (op_raw > 5) ? 0 : op_raw;
        m_carry = carry;
        sched.push_back(S_LOAD);
        sched.push_back(S_EXEC);
      end
      return;
    end
    s = sched.pop_front();
    if (s == S_EXEC) begin
      // Forward offsets cross on carry; backward offsets cross on no carry.
      page_cross = (m_op == 3) ? cout : (m_op == 4) ? (cout != sign) : 1'b0;
      m_backward = (m_op == 4) && sign;
      if (page_cross) sched.push_back(S_FIXUP);
      sched.push_back(S_DONE);
    end
  endtask

  initial begin
    int   op_raw;
    logic r_n, rdy, st, cf, co, bs;
    reset          = 1'b0;
    bus.rdy        = 1'b0;
    bus.start      = 1'b0;
    bus.op         = OP_ADD;
    bus.carry_flag = 1'b0;
    bus.alu_cout   = 1'b0;
    bus.b_sign     = 1'b0;
    m_op = 0; m_carry = 1'b0; m_backward = 1'b0;
    repeat (2) @(posedge clk);
    advance_model(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      r_n    = (cyc < 2) ? 1'b0 : ($urandom_range(0, 99) >= 2);
      rdy    = ($urandom_range(0, 99) >= 20);
      st     = ($urandom_range(0, 99) < 60);
      op_raw = int'($urandom_range(0, 7));
      cf     = 1'($urandom);
      co     = 1'($urandom);
      bs     = 1'($urandom);
      reset          = r_n;
      bus.rdy        = rdy;
      bus.start      = st;
      bus.op         = alu_op_t'(3'(op_raw));
      bus.carry_flag = cf;
      bus.alu_cout   = co;
      bus.b_sign     = bs;
      #1;
      check(r_n ? "outputs" : "reset_outputs", observed, predict(r_n, rdy));
      advance_model(r_n, rdy, st, op_raw, cf, co, bs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
